// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector. It takes valid-qualified bits, supports overlapping
// or non-overlapping matches, and keeps a saturating count of matches since the last start.
module seq_det_param #(
  parameter int PATTERN_W = 4,
  parameter int OVERLAP   = 1,
  parameter int COUNT_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic                 valid_i,
  input  logic                 serial_i,
  output logic                 busy_o,
  output logic                 detected_o,
  output logic [COUNT_W-1:0]   match_cnt_o
);

  localparam int BC_W = $clog2(PATTERN_W + 1);
  localparam logic [BC_W-1:0]    BC_FULL = BC_W'(PATTERN_W);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_n;
  logic [PATTERN_W-1:0] sr, sr_n, sr_shift;
  logic [PATTERN_W-1:0] pat, pat_n;
  logic [BC_W-1:0]      bc, bc_n, bc_inc;
  logic                 det_n;
  logic [COUNT_W-1:0]   cnt_n;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      sr          <= '0;
      pat         <= '0;
      bc          <= '0;
      detected_o  <= 1'b0;
      match_cnt_o <= '0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      pat         <= pat_n;
      bc          <= bc_n;
      detected_o  <= det_n;
      match_cnt_o <= cnt_n;
    end
  end

  assign sr_shift = {sr[PATTERN_W-2:0], serial_i};
  assign bc_inc   = (bc == BC_FULL) ? bc : bc + BC_W'(1);

  // A match is judged on the post-shift history, so the pulse lands right after the last bit.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    pat_n   = pat;
    bc_n    = bc;
    det_n   = 1'b0;
    cnt_n   = match_cnt_o;
    if (start_i) begin
      state_n = RUN;
      pat_n   = pattern_i;
      sr_n    = '0;
      bc_n    = '0;
      cnt_n   = '0;
    end else if (state == RUN) begin
      if (stop_i) begin
        state_n = IDLE;
      end else if (valid_i) begin
        sr_n = sr_shift;
        bc_n = bc_inc;
        if (bc_inc == BC_FULL && sr_shift == pat) begin
          det_n = 1'b1;
          if (match_cnt_o != CNT_MAX) cnt_n = match_cnt_o + COUNT_W'(1);
          if (OVERLAP == 0) bc_n = '0;
        end
      end
    end
  end

  assign busy_o = (state == RUN);

endmodule

// File: tb/tb_seq_det_param.sv
// Drives three detector variants (overlap, non-overlap, 2-bit counter) with one shared stream
// and scoreboards every detected_o pulse against hand-computed edge/count expectations.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rstn_i;
  logic       start_i, stop_i, valid_i, serial_i;
  logic [3:0] pattern_i;
  logic       busy0, busy1, busy2, det0, det1, det2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  logic [2:0] det, busy;
  int         cnt_act [3];
  int         q_edge [3][$];
  int         q_cnt  [3][$];
  int         edge_no  = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  seq_det_param #(.PATTERN_W(4), .OVERLAP(1), .COUNT_W(8)) dut_ov (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i), .pattern_i(pattern_i),
    .valid_i(valid_i), .serial_i(serial_i), .busy_o(busy0), .detected_o(det0), .match_cnt_o(cnt0));
  seq_det_param #(.PATTERN_W(4), .OVERLAP(0), .COUNT_W(8)) dut_nov (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i), .pattern_i(pattern_i),
    .valid_i(valid_i), .serial_i(serial_i), .busy_o(busy1), .detected_o(det1), .match_cnt_o(cnt1));
  seq_det_param #(.PATTERN_W(4), .OVERLAP(1), .COUNT_W(2)) dut_c2 (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i), .pattern_i(pattern_i),
    .valid_i(valid_i), .serial_i(serial_i), .busy_o(busy2), .detected_o(det2), .match_cnt_o(cnt2));

  assign det  = {det2, det1, det0};
  assign busy = {busy2, busy1, busy0};
  always_comb begin
    cnt_act[0] = int'(cnt0);
    cnt_act[1] = int'(cnt1);
    cnt_act[2] = int'(cnt2);
  end

  // Monitor: every pulse must match the oldest queued expectation in edge and count.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (det[k]) begin
        n_checks++;
        if (q_edge[k].size() == 0) begin
          n_fail++;
          $display("[TB] FAIL pulse_dut%0d: detected_o at edge %0d, required no pulse", k, edge_no);
        end else begin
          int e, c;
          e = q_edge[k].pop_front();
          c = q_cnt[k].pop_front();
          if (e != edge_no || c != cnt_act[k]) begin
            n_fail++;
            $display("[TB] FAIL pulse_dut%0d: got edge %0d cnt %0d, required edge %0d cnt %0d",
                     k, edge_no, cnt_act[k], e, c);
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic st, sp, v, s, input int e0, e1, e2);
    int ex[3];
    ex = '{e0, e1, e2};
    start_i  = st;
    stop_i   = sp;
    valid_i  = v;
    serial_i = s;
    for (int k = 0; k < 3; k++) begin
      if (ex[k] > 0) begin
        q_edge[k].push_back(edge_no + 1);
        q_cnt[k].push_back(ex[k]);
      end
    end
    @(posedge clk);
    edge_no++;
    #1;
  endtask

  task automatic bit_in(input logic s, input int e0, e1, e2);
    apply_stimulus(1'b0, 1'b0, 1'b1, s, e0, e1, e2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int b, input int c0, c1, c2);
    for (int k = 0; k < 3; k++) check_output($sformatf("%s_busy%0d", name, k), int'(busy[k]), b);
    check_output($sformatf("%s_cnt0", name), cnt_act[0], c0);
    check_output($sformatf("%s_cnt1", name), cnt_act[1], c1);
    check_output($sformatf("%s_cnt2", name), cnt_act[2], c2);
  endtask

  task automatic start_run(input logic [3:0] p);
    pattern_i = p;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    rstn_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; valid_i = 1'b0; serial_i = 1'b0;
    pattern_i = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) check_output($sformatf("reset_det%0d", k), int'(det[k]), 0);
    #2 rstn_i = 1'b1;
    idle(2);

    // Stream 1,1,1,1,0,1,1,0,1 with pattern 1101
    start_run(4'b1101);
    check_all("start1", 1, 0, 0, 0);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0);
    bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 1); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
    bit_in(1, 2, 0, 2);
    idle(2);
    check_all("stream", 1, 2, 1, 2);

    // Gapped bits; pattern_i changes mid-run must be ignored
    start_run(4'b1101);
    pattern_i = 4'b0000;
    bit_in(1, 0, 0, 0); idle(3);
    bit_in(1, 0, 0, 0); idle(3);
    bit_in(0, 0, 0, 0); idle(3);
    bit_in(1, 1, 1, 1); idle(3);
    check_all("gapped", 1, 1, 1, 1);

    // Ten ones against 1111: overlap pulses every bit from the 4th on
    start_run(4'b1111);
    for (int i = 1; i <= 10; i++)
      bit_in(1, (i >= 4) ? i - 3 : 0, (i == 4) ? 1 : (i == 8) ? 2 : 0,
             (i >= 4) ? ((i - 3 > 3) ? 3 : i - 3) : 0);
    idle(2);
    check_all("ones", 1, 7, 2, 3);

    // Restart mid-stream clears history and count; the start-cycle bit is dropped
    start_run(4'b1101);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 1);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    check_all("restart", 1, 0, 0, 0);
    bit_in(1, 0, 0, 0);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 1);
    idle(2);
    check_all("after_restart", 1, 1, 1, 1);

    // Asynchronous reset mid-run with three bits in hand
    start_run(4'b1101);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 1);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0);
    #3 rstn_i = 1'b0;
    #1;
    check_all("midreset", 0, 0, 0, 0);
    #2 rstn_i = 1'b1;
    bit_in(1, 0, 0, 0);
    idle(2);
    check_all("post_reset", 0, 0, 0, 0);

    // Stop drops busy next cycle, holds count, and ignores later bits
    start_run(4'b1101);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 1, 1, 1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    check_all("stop", 0, 1, 1, 1);
    bit_in(1, 0, 0, 0); bit_in(1, 0, 0, 0); bit_in(0, 0, 0, 0); bit_in(1, 0, 0, 0);
    idle(3);
    check_all("idle_held", 0, 1, 1, 1);

    for (int k = 0; k < 3; k++)
      check_output($sformatf("pending_pulses_dut%0d", k), q_edge[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
